// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
//   Self-test sequencer for a 4-bit ALU. It drives registered operand/opcode
//   vectors to an external ALU, waits one settle cycle, and compares the ALU's
//   combinational response against an internal golden model. It runs either a
//   single configured vector or an exhaustive sweep of all 2048 vectors, and
//   reports an error count, the first failing vector and a pass flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, sweep             run request (IDLE only), sweep/single select
//   cfg_a, cfg_b, cfg_ctrl   single-mode vector
//   alu_a, alu_b, alu_ctrl   registered vector driven to the ALU
//   alu_res, alu_car, alu_of ALU response
//   busy, done, pass         run status
//   err_cnt                  saturating mismatch count
//   err_a, err_b, err_ctrl   first failing vector of the run
// -----------------------------------------------------------------------------
module alu_driver (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       sweep,
   input  logic [3:0] cfg_a,
   input  logic [3:0] cfg_b,
   input  logic [2:0] cfg_ctrl,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_ctrl,
   input  logic [3:0] alu_res,
   input  logic       alu_car,
   input  logic       alu_of,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt,
   output logic [3:0] err_a,
   output logic [3:0] err_b,
   output logic [2:0] err_ctrl
);

   typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  a_q, a_d, b_q, b_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        sweep_q, sweep_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [3:0]  err_a_q, err_a_d, err_b_q, err_b_d;
   logic [2:0]  err_ctrl_q, err_ctrl_d;
   logic        pass_q, pass_d;

   // Golden model
   logic [3:0]  exp_res;
   logic        exp_car, exp_of;
   logic [4:0]  sum5;
   logic [3:0]  neg_b;

   always_comb begin
      exp_res = 4'd0;
      exp_car = 1'b0;
      exp_of  = 1'b0;
      neg_b   = (~b_q) + 4'd1;
      sum5    = 5'd0;
      case (ctrl_q)
         3'b000: begin
            sum5    = {1'b0, a_q} + {1'b0, b_q};
            exp_res = sum5[3:0];
            exp_car = sum5[4];
            exp_of  = (a_q[3] == b_q[3]) & (sum5[3] != a_q[3]);
         end
         3'b001: begin
            sum5    = {1'b0, a_q} + {1'b0, neg_b};
            exp_res = sum5[3:0];
            exp_car = sum5[4];
            // Overflow term deliberately uses the raw b operand, not its negation.
            exp_of  = (a_q[3] == b_q[3]) & (sum5[3] != a_q[3]);
         end
         3'b010: exp_res = ~a_q;
         3'b011: exp_res = a_q & b_q;
         3'b100: exp_res = a_q | b_q;
         3'b101: exp_res = a_q ^ b_q;
         3'b110: begin
            if (a_q[3] != b_q[3]) exp_res = {3'b000, a_q[3]};
            else                  exp_res = (a_q < b_q) ? 4'd0 : 4'd1;
         end
         default: exp_res = (a_q == b_q) ? 4'd0 : 4'd1;
      endcase
   end

   logic        mismatch;
   logic        last_vec;
   logic [10:0] vec, vec_nxt;

   assign mismatch = {alu_res, alu_car, alu_of} != {exp_res, exp_car, exp_of};
   assign vec      = {ctrl_q, a_q, b_q};
   assign vec_nxt  = vec + 11'd1;
   assign last_vec = ~sweep_q | (vec == 11'h7FF);

   // Next-state and outputs
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      sweep_d    = sweep_q;
      err_cnt_d  = err_cnt_q;
      err_a_d    = err_a_q;
      err_b_d    = err_b_q;
      err_ctrl_d = err_ctrl_q;
      pass_d     = pass_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d        = sweep ? 4'd0 : cfg_a;
               b_d        = sweep ? 4'd0 : cfg_b;
               ctrl_d     = sweep ? 3'd0 : cfg_ctrl;
               sweep_d    = sweep;
               err_cnt_d  = 8'd0;
               err_a_d    = 4'd0;
               err_b_d    = 4'd0;
               err_ctrl_d = 3'd0;
               pass_d     = 1'b0;
               state_d    = StDrive;
            end
         end
         StDrive: state_d = StCheck;
         StCheck: begin
            if (mismatch) begin
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               // A zero count means no earlier failure in this run.
               if (err_cnt_q == 8'd0) begin
                  err_a_d    = a_q;
                  err_b_d    = b_q;
                  err_ctrl_d = ctrl_q;
               end
            end
            if (last_vec) begin
               pass_d  = (err_cnt_d == 8'd0);
               state_d = StDone;
            end else begin
               {ctrl_d, a_d, b_d} = vec_nxt;
               state_d = StDrive;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= 4'd0;
         b_q        <= 4'd0;
         ctrl_q     <= 3'd0;
         sweep_q    <= 1'b0;
         err_cnt_q  <= 8'd0;
         err_a_q    <= 4'd0;
         err_b_q    <= 4'd0;
         err_ctrl_q <= 3'd0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ctrl_q     <= ctrl_d;
         sweep_q    <= sweep_d;
         err_cnt_q  <= err_cnt_d;
         err_a_q    <= err_a_d;
         err_b_q    <= err_b_d;
         err_ctrl_q <= err_ctrl_d;
         pass_q     <= pass_d;
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_ctrl = ctrl_q;
   assign busy     = (state_q == StDrive) | (state_q == StCheck);
   assign done     = (state_q == StDone);
   assign pass     = pass_q;
   assign err_cnt  = err_cnt_q;
   assign err_a    = err_a_q;
   assign err_b    = err_b_q;
   assign err_ctrl = err_ctrl_q;

endmodule

// File: tb/tb_alu_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_driver
//   Bench for alu_driver. A behavioural ALU with selectable faults answers the
//   DUT; expected results come from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_driver;

   logic       clk = 1'b0;
   logic       rst, start, sweep;
   logic [3:0] cfg_a, cfg_b;
   logic [2:0] cfg_ctrl;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_ctrl;
   logic [3:0] alu_res;
   logic       alu_car, alu_of;
   logic       busy, done, pass;
   logic [7:0] err_cnt;
   logic [3:0] err_a, err_b;
   logic [2:0] err_ctrl;

   int n_cmp = 0;
   int n_bad = 0;
   int fault_mode = 0; // 0 good, 1 res[0] stuck-0, 2 res forced 0, 3 carry flipped

   always #5 clk = ~clk;

   alu_driver dut (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ctrl(cfg_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .err_a(err_a), .err_b(err_b), .err_ctrl(err_ctrl)
   );

   // Reference: returns {res[3:0], car, of}
   function automatic logic [5:0] ref_model(input int a, input int b, input int op);
      int s, res, car, of, sa, sb, sr;
      res = 0; car = 0; of = 0;
      sa = a / 8; sb = b / 8;
      case (op)
         0: begin s = a + b; res = s % 16; car = s / 16; end
         1: begin s = a + ((16 - b) % 16); res = s % 16; car = s / 16; end
         2: res = 15 - a;
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = (sa != sb) ? sa : ((a < b) ? 0 : 1);
         default: res = (a == b) ? 0 : 1;
      endcase
      sr = res / 8;
      if (op <= 1) of = ((sa == sb) && (sr != sa)) ? 1 : 0;
      return {res[3:0], car[0], of[0]};
   endfunction

   function automatic logic [5:0] alu_resp(input int a, input int b, input int op, input int m);
      logic [5:0] r;
      r = ref_model(a, b, op);
      case (m)
         1: r[2] = 1'b0;
         2: r[5:2] = 4'd0;
         3: r[1] = ~r[1];
         default: ;
      endcase
      return r;
   endfunction

   assign {alu_res, alu_car, alu_of} = alu_resp(int'(alu_a), int'(alu_b), int'(alu_ctrl),
                                                fault_mode);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vec"}, {21'd0, alu_a, alu_b, alu_ctrl}, 32'd0);
      chk({tag, "_stat"}, {10'd0, busy, done, pass, err_cnt, err_a, err_b, err_ctrl}, 32'd0);
   endtask

   // Single-vector run; start edge -> cycles 1 (DRIVE), 2 (CHECK), 3 (DONE).
   task automatic run_single(input int a, input int b, input int op, input int m);
      logic [5:0] good, got;
      int         bad;
      good = ref_model(a, b, op);
      got  = alu_resp(a, b, op, m);
      bad  = (good != got) ? 1 : 0;
      fault_mode = m;
      cfg_a = 4'(a); cfg_b = 4'(b); cfg_ctrl = 3'(op); sweep = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("s_vec", {21'd0, alu_ctrl, alu_a, alu_b}, (op << 8) | (a << 4) | b);
      chk("s_busy1", {29'd0, busy, done, pass}, 32'b100);
      tick();
      chk("s_busy2", {29'd0, busy, done, pass}, 32'b100);
      tick();
      chk("s_done", {29'd0, busy, done, pass}, {29'd0, 1'b0, 1'b1, bad == 0});
      chk("s_errcnt", {24'd0, err_cnt}, bad);
      chk("s_errvec", {21'd0, err_ctrl, err_a, err_b},
          bad != 0 ? ((op << 8) | (a << 4) | b) : 0);
      tick();
      chk("s_hold", {29'd0, busy, done, pass}, {31'd0, bad == 0});
   endtask

   // Full sweep; optional reset at cycle abort_at (0 = none).
   task automatic run_sweep(input int m, input int abort_at);
      int cnt, first;
      logic [5:0] good, got;
      cnt = 0; first = -1;
      for (int i = 0; i < 2048; i++) begin
         good = ref_model((i / 16) % 16, i % 16, i / 256);
         got  = alu_resp((i / 16) % 16, i % 16, i / 256, m);
         if (good != got) begin
            if (first < 0) first = i;
            cnt++;
         end
      end
      if (cnt > 255) cnt = 255;
      if (first < 0) first = 0;
      fault_mode = m;
      cfg_a = 4'($urandom); cfg_b = 4'($urandom); cfg_ctrl = 3'($urandom);
      sweep = 1'b1; start = 1'b1;
      for (int c = 1; c <= 4097; c++) begin
         tick();
         // start held for a few cycles must be ignored while busy
         if (c == 6) start = 1'b0;
         if (c <= 4096) begin
            // index of the vector in sweep order (ctrl, a, b from MSB to LSB)
            chk("w_vec", {21'd0, alu_ctrl, alu_a, alu_b}, (c - 1) / 2);
            chk("w_busy", {30'd0, busy, done}, 32'b10);
         end else begin
            chk("w_done", {29'd0, busy, done, pass}, {29'd0, 2'b01, cnt == 0});
            chk("w_errcnt", {24'd0, err_cnt}, cnt);
            chk("w_errvec", {21'd0, err_ctrl, err_a, err_b}, first);
         end
         if (c == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_zero("abort");
            for (int k = 0; k < 5; k++) begin
               tick();
               chk("abort_idle", {30'd0, busy, done}, 32'd0);
            end
            return;
         end
      end
      tick();
      chk("w_after", {29'd0, busy, done, pass}, {31'd0, cnt == 0});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sweep = 1'b0;
      cfg_a = 4'd0; cfg_b = 4'd0; cfg_ctrl = 3'd0;
      tick();
      tick();
      rst = 1'b0;
      chk_zero("reset");

      // rst and start on the same edge: rst wins
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk_zero("rst_start");
      tick();
      chk("rst_start_idle", {31'd0, busy}, 32'd0);

      // Directed single runs
      run_single(5, 3, 1, 0);
      run_single(5, 0, 1, 0);
      run_single(8, 7, 6, 2);
      run_single(8, 7, 6, 0);
      run_single(15, 1, 0, 0);
      run_single(7, 1, 0, 3);

      // Randomized single runs with random faults
      for (int n = 0; n < 24; n++)
         run_single(int'($urandom_range(15)), int'($urandom_range(15)),
                    int'($urandom_range(7)), int'($urandom_range(3)));

      // Sweeps: good ALU, stuck bit, aborted, then a clean full sweep
      run_sweep(0, 0);
      run_sweep(1, 0);
      run_sweep(0, 100);
      run_sweep(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
